// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared arithmetic definitions for the nibble-serial subtractor.
package arith_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Number of nibbles needed to cover an operand of the given width.
  function automatic int num_nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

  // Counter width for a nibble index, never narrower than one bit.
  function automatic int idx_width(input int width);
    return (num_nibbles(width) > 1) ? $clog2(num_nibbles(width)) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_borrow_lookahead4.sv
// 4-bit borrow-lookahead subtract slice: d = a - b - bin, every borrow
// expressed directly from generate/propagate terms and bin.
module borrow_lookahead4
  import arith_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                bin_i,
  output logic [NIBBLE_W-1:0] d_o,
  output logic                bout_o
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   br;

  assign g = ~a_i & b_i;
  assign p = ~(a_i ^ b_i);

  assign br[0] = bin_i;
  assign br[1] = g[0] | (p[0] & bin_i);
  assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin_i);
  assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bin_i);
  assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bin_i);

  assign d_o    = a_i ^ b_i ^ br[NIBBLE_W-1:0];
  assign bout_o = br[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one nibble per clock, LSB first.
// Published diff/bout/ovf only change on the completion edge.
module nibble_serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             ovf_o
);

  localparam int N  = num_nibbles(WIDTH);
  localparam int KW = idx_width(WIDTH);

  if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
    $error("nibble_serial_subtractor: WIDTH must be a positive multiple of 4");
  end

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [NIBBLE_W-1:0] a_nib, b_nib, d_nib;
  logic                br_nib;
  logic [KW+1:0]       nib_base;
  logic                last_nib;

  // Single shared slice; the active nibble is selected by k.
  assign nib_base = {k_q, 2'b00};
  assign a_nib    = a_q[nib_base +: NIBBLE_W];
  assign b_nib    = b_q[nib_base +: NIBBLE_W];
  assign last_nib = (k_q == KW'(N - 1));

  borrow_lookahead4 u_slice (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .bin_i  (br_q),
    .d_o    (d_nib),
    .bout_o (br_nib)
  );

  // Next-state and datapath control; everything holds unless updated below.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    work_d  = work_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          br_d    = bin_i;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[nib_base +: NIBBLE_W] = d_nib;
        br_d = br_nib;
        if (last_nib) begin
          k_d     = '0;
          state_d = IDLE;
          diff_d  = work_d;
          bout_d  = br_nib;
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
          done_d  = 1'b1;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working and published registers; reset aborts any operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      work_q  <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      work_q  <= work_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = done_q;
  assign diff_o = diff_q;
  assign bout_o = bout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH = 16).
module tb_nibble_serial_subtractor;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .bin_i   (bin),
    .busy_o  (busy),
    .done_o  (done),
    .diff_o  (diff),
    .bout_o  (bout),
    .ovf_o   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, bout, diff} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    int unsigned ux;
    int unsigned uy;
    int          sx;
    int          sy;
    int          sd;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    ux = x;
    uy = y;
    sx = int'($signed(x));
    sy = int'($signed(y));
    d  = W'(ux - uy - c);
    bo = (ux < uy + c);
    sd = sx - sy - int'(c);
    ov = (sd > 32767) || (sd < -32768);
    return {ov, bo, d};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, bout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%0b done=%0b diff=%h bout=%0b ovf=%0b required all 0",
               busy, done, diff, bout, ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%0b done=%0b required 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [6];
    logic [W-1:0] vb [6];
    logic         vc [6];
    logic [W+1:0] exp_r;
    va = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    vb = '{16'h0234, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vc = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1};
    for (int v = 0; v < 6; v++) begin
      exp_r = ref_sub(va[v], vb[v], vc[v]);
      start = 1'b1; a = va[v]; b = vb[v]; bin = vc[v];
      @(posedge clk); #1;
      start = 1'b0;
      a = ~va[v]; b = ~vb[v];
      for (int c = 1; c <= N; c++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL dir%0d_busy_c%0d busy=%0b done=%0b required 1 0", v, c - 1, busy, done);
        end
        @(posedge clk); #1;
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_done busy=%0b done=%0b required 0 1", v, busy, done);
      end
      checks++;
      if ({ovf, bout, diff} !== exp_r) begin
        errors++;
        $display("FAIL dir%0d_result diff=%h bout=%0b ovf=%0b required diff=%h bout=%0b ovf=%0b",
                 v, diff, bout, ovf, exp_r[W-1:0], exp_r[W], exp_r[W+1]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || {ovf, bout, diff} !== exp_r) begin
        errors++;
        $display("FAIL dir%0d_hold done=%0b diff=%h required done=0 diff=%h",
                 v, done, diff, exp_r[W-1:0]);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W+1:0] exp_r;
    int           n_done;
    exp_r  = ref_sub(16'hA5C3, 16'h3C5A, 1'b1);
    n_done = 0;
    start = 1'b1; a = 16'hA5C3; b = 16'h3C5A; bin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 16'h0001; b = 16'h0002; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < N + 3; c++) begin
      if (done === 1'b1) begin
        n_done++;
        checks++;
        if ({ovf, bout, diff} !== exp_r) begin
          errors++;
          $display("FAIL ignore_result diff=%h bout=%0b ovf=%0b required diff=%h bout=%0b ovf=%0b",
                   diff, bout, ovf, exp_r[W-1:0], exp_r[W], exp_r[W+1]);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL ignore_done_count got=%0d required 1", n_done);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [W+1:0] exp_r;
    int           n_done;
    n_done = 0;
    checks++;
    if (diff === '0) begin
      errors++;
      $display("FAIL midrst_precondition diff=%h required nonzero", diff);
    end
    start = 1'b1; a = 16'h4321; b = 16'h1234; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, diff, bout, ovf} !== '0) begin
      errors++;
      $display("FAIL midrst_async busy=%0b done=%0b diff=%h bout=%0b ovf=%0b required all 0",
               busy, done, diff, bout, ovf);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < N + 2; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_done dones=%0d busy=%0b required 0 0", n_done, busy);
    end
    exp_r = ref_sub(16'h00F0, 16'h0F00, 1'b0);
    start = 1'b1; a = 16'h00F0; b = 16'h0F00; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || {ovf, bout, diff} !== exp_r) begin
      errors++;
      $display("FAIL midrst_fresh done=%0b diff=%h bout=%0b ovf=%0b required done=1 diff=%h bout=%0b ovf=%0b",
               done, diff, bout, ovf, exp_r[W-1:0], exp_r[W], exp_r[W+1]);
    end
  endtask

  // Back-to-back random operations with start held; operands driven while
  // busy are noise that must not be captured.
  task automatic test_back_to_back(input int n_ops);
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic         ec;
    logic [W+1:0] exp_r;
    ea = W'($urandom); eb = W'($urandom); ec = 1'($urandom_range(0, 1));
    start = 1'b1; a = ea; b = eb; bin = ec;
    for (int op = 0; op < n_ops; op++) begin
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom_range(0, 1));
      exp_r = ref_sub(ea, eb, ec);
      repeat (N) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || {ovf, bout, diff} !== exp_r) begin
        errors++;
        $display("FAIL b2b_op%0d a=%h b=%h bin=%0b done=%0b busy=%0b diff=%h bout=%0b ovf=%0b required done=1 busy=0 diff=%h bout=%0b ovf=%0b",
                 op, ea, eb, ec, done, busy, diff, bout, ovf,
                 exp_r[W-1:0], exp_r[W], exp_r[W+1]);
      end
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {ovf, bout, diff} !== exp_r) begin
          errors++;
          $display("FAIL b2b_gap%0d done=%0b busy=%0b diff=%h required 0 0 %h",
                   op, done, busy, diff, exp_r[W-1:0]);
        end
        start = 1'b1;
      end
      ea = W'($urandom); eb = W'($urandom); ec = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) ea = '0;
      if ($urandom_range(0, 15) == 0) eb = '1;
      a = ea; b = eb; bin = ec;
    end
    start = 1'b0;
    @(posedge clk); #1;
    repeat (N + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid_op();
    test_back_to_back(10000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle WIDTH-bit subtractor that computes diff = a − b − bin four bits per clock. Each nibble goes through a combinational borrow-lookahead slice, and the borrow is registered between nibbles. It is the subtraction counterpart of the team's 4-bit carry-lookahead adder. It serves arithmetic datapaths that trade latency for area, using a start/done handshake with published results held stable between operations.

## Interface
Parameters:
- WIDTH, 16, operand width. Must be a multiple of 4 and ≥ 4. Any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request. Sampled only in IDLE.
- a  in  WIDTH  minuend. Captured when start is accepted.
- b  in  WIDTH  subtrahend. Captured when start is accepted.
- bin  in  1  borrow-in. Captured when start is accepted.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- diff  out  WIDTH  published difference.
- bout  out  1  published borrow-out (unsigned underflow).
- ovf  out  1  published signed overflow.

## Operation
- N = WIDTH/4 nibbles, processed LSB first.
- FSM states: IDLE and RUN.
  - IDLE → RUN when start = 1 at a rising edge.
  - RUN → IDLE at the edge that processes nibble N−1.
- On accept:
  - a and b go into working registers.
  - The borrow register loads bin.
  - The nibble index k resets to 0.
  - busy rises.
- Each RUN edge:
  - The slice takes a[4k+3:4k], b[4k+3:4k] and the borrow register.
  - The 4-bit difference is written to work_diff[4k+3:4k].
  - The borrow register takes the slice's borrow-out.
  - k increments.
- Slice equations:
  - g_i = ~a_i & b_i
  - p_i = ~(a_i ^ b_i)
  - d_i = a_i ^ b_i ^ br_i
  - br_(i+1) = g_i | (p_i & br_i), flattened into lookahead form for all four bit positions; no ripple through intermediate bits.
- Completion, at the final RUN edge:
  - diff takes the completed work_diff, including the nibble computed on that edge.
  - bout takes the final borrow.
  - ovf = (a[W−1] ≠ b[W−1]) & (diff[W−1] ≠ a[W−1]), using the captured operands.
  - done pulses high for one cycle.
- Published outputs (diff, bout, ovf) change only at completion and hold until the next completion. Partial results are never visible.
- start while busy is ignored. It is not queued, and the captured operands are unaffected.
- Arithmetic is modulo 2^WIDTH. bout = 1 iff a < b + bin (unsigned).

## Timing
- Reset values: busy = 0, done = 0, diff = 0, bout = 0, ovf = 0, state = IDLE, k = 0, borrow register = 0.
- Reset mid-operation aborts the operation:
  - No done pulse.
  - Outputs are forced to their reset values immediately (asynchronous assert).
  - Release is synchronous to the next edge.
- If start is accepted at edge t:
  - busy = 1 from t to t+N; it falls at edge t+N.
  - Nibble k is processed at edge t+1+k.
  - done = 1 for the cycle following edge t+N.
  - Outputs are valid in that same cycle.
- The earliest next accept is edge t+N+1, so throughput is one operation per N+1 cycles. start held continuously gives back-to-back operations at that rate.
- start coincident with the done cycle is accepted at the following edge (state is IDLE).
- WIDTH = 4 (N = 1): busy is high for one cycle, and done follows at t+1.

## Structure
- Shared package `arith_pkg`:
  - NIBBLE_W = 4.
  - FSM state enum {IDLE, RUN}.
  - A function or constant for N derived from WIDTH.
- Sub-module `borrow_lookahead4`: combinational, with inputs a[3:0], b[3:0], bin and outputs d[3:0], bout. It is instantiated once; the nibble operands are muxed by k.
- Top level contains the FSM, the k counter (clog2(N) bits, min 1), the working registers and the output registers.

## Test plan
WIDTH = 16 throughout.
- a = 0x1234, b = 0x0234, bin = 0 → diff = 0x1000, bout = 0, ovf = 0. done at edge t+4; busy high for cycles t..t+3.
- a = 0x0000, b = 0x0001, bin = 0 → diff = 0xFFFF, bout = 1, ovf = 0. The borrow must propagate through all four nibbles.
- a = 0x8000, b = 0x0001, bin = 0 → diff = 0x7FFF, bout = 0, ovf = 1. Also a = 0x7FFF, b = 0xFFFF → diff = 0x8000, ovf = 1, bout = 1.
- a = 0x0000, b = 0xFFFF, bin = 1 → diff = 0x0000, bout = 1, ovf = 0.
- Start, then pulse start with new operands at t+2 → ignored. The result matches the first operands, and exactly one done is seen.
- Assert rst at t+2 → busy/diff/bout/ovf = 0 immediately and no done. A fresh start after release completes normally. Also a random 10k-operation sweep against a reference model, including back-to-back starts.
